// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state type, limits and phase
// length helpers for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_e;

  localparam int MIN_DIV   = 2;
  localparam int CNT_W_DEF = 8;

  // High phase length for ratio d (floor half).
  function automatic logic [31:0] hi_len(
    input logic [31:0] d
  );
    return d >> 1;
  endfunction

  // Low phase length for ratio d (gets the odd cycle).
  function automatic logic [31:0] lo_len(
    input logic [31:0] d
  );
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clk_div_cfg_slot.sv
// clk_div_cfg_slot: config handshake slot. Holds one pending
// ratio while running, applies it in IDLE or at a period
// boundary, rejects ratios below MIN_DIV with a cfg_err pulse.
// Ports: clk_in, rst, cfg_valid/cfg_div in, idle/boundary
// status in; cfg_ready, cfg_err, cur_div, apply (comb strobe).
module clk_div_cfg_slot
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             idle,
  input  logic             boundary,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             apply
);

  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] pend_d_q, pend_d_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic             err_q, err_d;
  logic             fire, bad, good;

  assign cfg_ready = !pend_v_q;
  assign fire      = cfg_valid && cfg_ready;
  assign bad       = fire && (cfg_div < CNT_W'(MIN_DIV));
  assign good      = fire && !bad;

  always_comb begin
    pend_v_d  = pend_v_q;
    pend_d_d  = pend_d_q;
    cur_div_d = cur_div_q;
    err_d     = bad;
    apply     = 1'b0;
    if (good && (idle || boundary)) begin
      // Direct load: nothing in flight or the
      // period ends at this very edge.
      cur_div_d = cfg_div;
      apply     = 1'b1;
    end else if (good) begin
      pend_v_d = 1'b1;
      pend_d_d = cfg_div;
    end else if (pend_v_q && boundary) begin
      cur_div_d = pend_d_q;
      pend_v_d  = 1'b0;
      apply     = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pend_v_q  <= 1'b0;
      pend_d_q  <= '0;
      cur_div_q <= CNT_W'(DEFAULT_DIV);
      err_q     <= 1'b0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_d_q  <= pend_d_d;
      cur_div_q <= cur_div_d;
      err_q     <= err_d;
    end
  end

  assign cfg_err = err_q;
  assign cur_div = cur_div_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider producing a
// registered divided clock level and a rise-tick strobe.
// Ports: clk_in, rst (sync, high), enable, cfg_valid, cfg_div,
// cfg_ready, cfg_err, clk_out, rise_tick, running, cur_div.
// Option CLK_DIV_CTRL_PERIOD_CNT_EN adds period_cnt[15:0].
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  if ((DEFAULT_DIV < MIN_DIV) ||
      (DEFAULT_DIV > (2 ** CNT_W) - 1)) begin : g_bad_default
    $fatal(1, "clk_div_ctrl: DEFAULT_DIV out of range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] h_m1, l_m1;
  logic             boundary;
  logic             apply;

  assign h_m1 = CNT_W'(hi_len(32'(cur_div))) - CNT_W'(1);
  assign l_m1 = CNT_W'(lo_len(32'(cur_div))) - CNT_W'(1);

  // Last cycle of the low phase closes the period.
  assign boundary = (state_q == LOW) && (cnt_q == l_m1);

  clk_div_cfg_slot #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_slot (
    .clk_in   (clk_in),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .idle     (state_q == IDLE),
    .boundary (boundary),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .cur_div  (cur_div),
    .apply    (apply)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = HIGH;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      HIGH: begin
        if (cnt_q == h_m1) begin
          state_d = LOW;
          clk_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (boundary) begin
          cnt_d = '0;
          if (enable) begin
            state_d = HIGH;
            clk_d   = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        clk_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
    end
  end

  assign clk_out   = clk_q;
  assign rise_tick = rise_q;
  assign running   = (state_q != IDLE);

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  // A newly applied ratio restarts the count.
  always_comb begin
    pcnt_d = pcnt_q;
    if (apply) begin
      pcnt_d = '0;
    end else if (rise_d) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign period_cnt = pcnt_q;
`else
  logic unused_apply;
  assign unused_apply = apply;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl against
// a period-position reference model.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       rise_tick;
  logic       running;
  logic [7:0] cur_div;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  clk_div_ctrl #(
    .CNT_W      (8),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in   (clk),
    .rst      (rst),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .clk_out  (clk_out),
    .rise_tick(rise_tick),
    .running  (running),
    .cur_div  (cur_div)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        clk;
    logic        rise;
    logic        run;
    logic [7:0]  div;
    logic        rdy;
    logic        err;
    logic [15:0] pc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Reference model: position inside the current period.
  int m_run, m_pos, m_div, m_pv, m_pd, m_pc;

  task automatic cyc(input bit r, input bit en,
                     input bit v, input int d);
    exp_t e;
    bit fire, rej, bnd, start, applied;
    rst       = r;
    enable    = en;
    cfg_valid = v;
    cfg_div   = 8'(d);
    start     = 0;
    applied   = 0;
    rej       = 0;
    if (r) begin
      m_run = 0; m_pos = 0; m_div = 4;
      m_pv  = 0; m_pd  = 0; m_pc  = 0;
    end else begin
      fire = v && (m_pv == 0);
      rej  = fire && (d < 2);
      bnd  = (m_run != 0) && (m_pos == m_div - 1);
      if (fire && !rej && (m_run == 0 || bnd)) begin
        m_div = d; applied = 1;
      end else if (fire && !rej) begin
        m_pv = 1; m_pd = d;
      end else if (m_pv != 0 && bnd) begin
        m_div = m_pd; m_pv = 0; applied = 1;
      end
      if (m_run == 0) begin
        if (en) begin m_run = 1; m_pos = 0; start = 1; end
      end else if (bnd) begin
        m_pos = 0;
        if (en) start = 1;
        else m_run = 0;
      end else begin
        m_pos++;
      end
      if (applied) m_pc = 0;
      else if (start) m_pc = (m_pc + 1) % 65536;
    end
    e.clk  = (m_run != 0) && (m_pos < (m_div / 2));
    e.rise = start;
    e.run  = (m_run != 0);
    e.div  = 8'(m_div);
    e.rdy  = (m_pv == 0);
    e.err  = rej;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    e.pc   = 16'(m_pc);
`else
    e.pc   = 16'd0;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input bit en, input int n);
    for (int i = 0; i < n; i++) cyc(0, en, 0, 0);
  endtask

  // Holds cfg_valid until the model's slot accepts it.
  task automatic cfg_req(input bit en, input int d);
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      done = (m_pv == 0);
      cyc(0, en, 1, d);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL cfg_accept act=stalled req=accepted d=%0d", d);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations.
  exp_t me, ma;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        ma.clk  = clk_out;
        ma.rise = rise_tick;
        ma.run  = running;
        ma.div  = cur_div;
        ma.rdy  = cfg_ready;
        ma.err  = cfg_err;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        ma.pc   = period_cnt;
`else
        ma.pc   = 16'd0;
`endif
        total++;
        ncyc++;
        if (ma !== me) begin
          bad++;
          $display("FAIL cyc%0d clk/rise/run/div/rdy/err/pc act=%b/%b/%b/%0d/%b/%b/%0d req=%b/%b/%b/%0d/%b/%b/%0d",
                   ncyc, ma.clk, ma.rise, ma.run, ma.div, ma.rdy,
                   ma.err, ma.pc, me.clk, me.rise, me.run, me.div,
                   me.rdy, me.err, me.pc);
        end
      end
    end
  end

  initial begin
    bit hold;
    int hd;
    bit en;
    rst = 1; enable = 0; cfg_valid = 0; cfg_div = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // D=4 free run
    idle_n(1, 13);
    idle_n(0, 6);
    // D=5 loaded in IDLE
    cfg_req(0, 5);
    idle_n(1, 16);
    idle_n(0, 8);
    // Mid-HIGH change 4 -> 2
    cfg_req(0, 4);
    idle_n(1, 2);
    cfg_req(1, 2);
    idle_n(1, 10);
    // Rejected ratios
    cfg_req(1, 1);
    idle_n(1, 2);
    cfg_req(1, 0);
    idle_n(1, 6);
    idle_n(0, 6);
    // Stop in first HIGH cycle at D=6
    cfg_req(0, 6);
    cyc(0, 1, 0, 0);
    idle_n(0, 12);
    // Reset during HIGH at D=8
    cfg_req(0, 8);
    idle_n(1, 2);
    cyc(1, 1, 0, 0);
    idle_n(1, 14);
    // Boundary-cycle handshake bypass
    cfg_req(1, 3);
    idle_n(1, 5);
    cfg_req(1, 7);
    idle_n(1, 20);
    // Random traffic
    hold = 0; hd = 0; en = 1;
    for (int i = 0; i < 600; i++) begin
      bit r, acc;
      r = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 24) == 0) en = !en;
      if (!hold && $urandom_range(0, 7) == 0) begin
        hold = 1;
        hd = ($urandom_range(0, 9) == 0) ?
             int'($urandom_range(0, 255)) :
             int'($urandom_range(0, 12));
      end
      acc = !r && (m_pv == 0);
      cyc(r, en, hold, hd);
      if (hold && acc) hold = 0;
    end
    idle_n(0, 2);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d req=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Runtime-programmable clock-divider controller. It generates a divided clock-level output and a rise-tick strobe from clk_in.
- Accepts new divide ratios over a valid/ready config handshake.
- Applies a new ratio only at a period boundary.
- Starts and stops cleanly, with no runt pulses.
- Sits between the system config/CSR logic and consumers of divided clocks or clock enables, replacing fixed-N dividers wherever the ratio must change at runtime.

Parameters:
- CNT_W, 8, width of divide ratio and internal phase counter; max ratio 2^CNT_W-1.
- DEFAULT_DIV, 4, ratio loaded at reset; must be in [2, 2^CNT_W-1] (elaboration-time check, fatal otherwise).

Ports:
- clk_in  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = run divider, 0 = stop at the end of the current period.
- cfg_valid  in  1  config request valid.
- cfg_div  in  CNT_W  requested divide ratio.
- cfg_ready  out  1  config slot free.
- cfg_err  out  1  one-cycle pulse: accepted request rejected (cfg_div < 2).
- clk_out  out  1  divided clock level (registered).
- rise_tick  out  1  one-cycle pulse in the cycle clk_out goes 0->1.
- running  out  1  state != IDLE.
- cur_div  out  CNT_W  ratio currently in effect.

Behaviour:
- Clocking and reset: single clock domain; everything happens on the clk_in rising edge.
- Reset values (rst=1): state=IDLE, clk_out=0, rise_tick=0, running=0, cur_div=DEFAULT_DIV, pending cleared, cfg_ready=1, cfg_err=0, counter=0.
- Reset mid-operation: takes effect at the next edge and may truncate a high phase; this is accepted.
- Phase lengths for ratio D: H = D>>1 cycles high, L = D-H cycles low.
  - D=2: 1/1. D=4: 2/2. D=5: 2/3.
  - Period = D cycles exactly.
- States: IDLE, HIGH, LOW.
- IDLE, enable=1: at the next edge go to HIGH; clk_out=1, rise_tick=1, counter=0.
- HIGH: counter increments each cycle; when counter==H-1, go to LOW, clk_out=0, counter=0.
- LOW: when counter==L-1 (period boundary):
  - enable=1: go to HIGH, clk_out=1, rise_tick=1.
  - enable=0: go to IDLE, clk_out stays 0.
- Dropping enable during HIGH or LOW always completes the current period; no runt pulses.
- Config handshake: transfer when cfg_valid && cfg_ready.
  - cfg_ready = !pending.
  - cfg_div < 2: no pending, cur_div unchanged, cfg_err=1 for the next cycle.
- Config while in IDLE: cur_div <= cfg_div at the next edge; pending never set.
- Config while running: cfg_div is stored as pending; cfg_ready=0 until applied.
  - Applied at the next period-boundary edge (LOW->HIGH or LOW->IDLE): cur_div updated, pending cleared, cfg_ready=1 next cycle.
  - The new period uses the new ratio.
- Handshake on the boundary cycle itself: the ratio is applied at that same edge, bypassing pending.
- A second request while pending is stalled (cfg_ready=0); the requester holds cfg_valid.
- The counter never wraps: it is compared against H-1/L-1 of the latched cur_div, so a ratio change mid-period cannot corrupt the count.

Optional Feature:
CLK_DIV_CTRL_PERIOD_CNT_EN
- Defined: adds output period_cnt [15:0].
  - Increments on each rise_tick and wraps 0xFFFF->0.
  - Clears on rst and on each applied config.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package clk_div_pkg holds:
  - state enum (IDLE, HIGH, LOW);
  - localparam MIN_DIV=2;
  - default CNT_W;
  - helper function computing H and L from D.
- One sub-module: clk_div_cfg_slot. It holds the pending register, cfg_ready, cfg_err and the IDLE/boundary apply logic, and outputs cur_div plus an apply strobe.
- The phase counter and FSM stay in the top module.

Test Plan:
- Reset then enable=1, D=4: clk_out pattern 1,1,0,0 repeating; rise_tick every 4 cycles; running=1 one cycle after enable.
- In IDLE, write cfg_div=5, then enable: cur_div=5 next cycle; high 2 / low 3 cycles; rise_tick spacing 5.
- Running at D=4, write cfg_div=2 mid-HIGH: cfg_ready=0 until boundary; current period stays 4 cycles; then 1/1 toggling; cfg_ready=1 after apply.
- Write cfg_div=1 and cfg_div=0: cfg_err pulses one cycle each; cur_div and timing unchanged; cfg_ready stays 1.
- Deassert enable in the first HIGH cycle at D=6: the period completes (3 high, 3 low), then IDLE, clk_out=0, running=0, no further rise_tick.
- Assert rst during HIGH at D=8: next cycle clk_out=0, cur_div=4, IDLE. With CLK_DIV_CTRL_PERIOD_CNT_EN, period_cnt=0 after reset and counts 1,2,3 over three periods.
